// File: rtl/sfm_lane_accumulator_pkg.sv
// Shared types for the lane accumulator: FSM state encoding.
package sfm_lane_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } sfm_state_e;

endpackage

// File: rtl/sfm_sat_adder.sv
// One lane: unsigned accumulator + data, clamped to all-ones on carry-out.
module sfm_sat_adder #(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  ovf_o
);

  logic [ACC_WIDTH:0] raw;

  assign raw   = {1'b0, a_i} + (ACC_WIDTH+1)'(b_i);
  assign ovf_o = raw[ACC_WIDTH];
  assign sum_o = ovf_o ? '1 : raw[ACC_WIDTH-1:0];

endmodule

// File: rtl/sfm_lane_accumulator.sv
// Per-lane strobed accumulation of a multi-beat vector, emitted once on the
// last beat with a one-bubble handshake between vectors.
module sfm_lane_accumulator
  import sfm_lane_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_ROWS   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  data_i,
  input  logic [NUM_ROWS-1:0]                  strb_i,
  input  logic                                 last_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [NUM_ROWS-1:0][ACC_WIDTH-1:0]   acc_o,
  output logic [CNT_WIDTH-1:0]                 cnt_o,
  output logic [NUM_ROWS-1:0]                  sat_o
);

  if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_width
    $error("sfm_lane_accumulator: ACC_WIDTH must be >= DATA_WIDTH");
  end

  sfm_state_e                           state_q, state_d;
  logic                                 valid_q;
  logic [NUM_ROWS-1:0][ACC_WIDTH-1:0]   acc_q, acc_d, sum;
  logic [NUM_ROWS-1:0]                  sat_q, sat_d, ovf;
  logic [CNT_WIDTH-1:0]                 cnt_q, cnt_inc;
  logic                                 accept, first;

  assign ready_o = enable_i & (state_q != ST_OUT);
  assign accept  = valid_i & ready_o;
  assign first   = (state_q == ST_IDLE);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_lane
    sfm_sat_adder #(.ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_add (
      .a_i   (acc_q[i]),
      .b_i   (data_i[i]),
      .sum_o (sum[i]),
      .ovf_o (ovf[i])
    );
    // First beat of a vector overwrites rather than accumulates.
    assign acc_d[i] = first ? (strb_i[i] ? ACC_WIDTH'(data_i[i]) : '0)
                            : (strb_i[i] ? sum[i] : acc_q[i]);
    assign sat_d[i] = first ? 1'b0 : (sat_q[i] | (strb_i[i] & ovf[i]));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACC: if (accept) state_d = last_i ? ST_OUT : ST_ACC;
      ST_OUT:          if (ready_i) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
    end else if (enable_i) begin
      state_q <= state_d;
      valid_q <= (state_d == ST_OUT);
      if (accept) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
        cnt_q <= first ? CNT_WIDTH'(1) : cnt_inc;
      end
    end
  end

  assign valid_o = valid_q;
  assign acc_o   = acc_q;
  assign cnt_o   = cnt_q;
  assign sat_o   = sat_q;

endmodule
